// File: rtl/jam_cost_eval_pkg.sv
// Shared constants and types for the JAM job-assignment search.
// Permutations are packed with the job of worker i in bits [3i+2:3i].
package jam_pkg;

    localparam int N  = 8;
    localparam int CW = 7;
    localparam int SW = 10;
    localparam int IW = 3;
    localparam int PW = N * IW;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CMP,
        REQ,
        WAIT_LO,
        WAIT_HI,
        DONE
    } state_t;

    localparam logic [PW-1:0] IDENT_PERM = 24'hFAC688;
    localparam logic [PW-1:0] LAST_PERM  = 24'h053977;

    localparam logic [SW-1:0] MIN_INIT = '1;
    localparam logic [3:0]    CNT_MAX  = 4'd15;

    function automatic logic [IW-1:0] perm_field(input logic [PW-1:0] perm,
                                                 input logic [IW-1:0] idx);
        return perm[IW*idx +: IW];
    endfunction

endpackage

// File: rtl/jam_cost_eval_if.sv
// Cost-memory bus, generator handshake and result signals of the evaluator.
// The master side is the evaluator; the slave side is memory, generator and observer.
interface jam_cost_eval_if;
    import jam_pkg::*;

    logic [IW-1:0] W;
    logic [IW-1:0] J;
    logic [CW-1:0] Cost;
    logic          gen_start;
    logic          gen_done;
    logic [PW-1:0] perm_out;
    logic [PW-1:0] perm_in;
    logic [3:0]    MatchCount;
    logic [SW-1:0] MinCost;
    logic          Valid;

    modport master (
        output W, J, gen_start, perm_out, MatchCount, MinCost, Valid,
        input  Cost, gen_done, perm_in
    );

    modport slave (
        input  W, J, gen_start, perm_out, MatchCount, MinCost, Valid,
        output Cost, gen_done, perm_in
    );

endinterface

// File: rtl/jam_cost_eval.sv
// Evaluation controller of the JAM search: sums the eight costs of the current
// permutation, tracks the minimum total and its tie count, and drives the generator loop.
module jam_cost_eval
    import jam_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    jam_cost_eval_if.master jam
);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_gen_start;

    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_w;
    logic [IW-1:0] r_j;
    logic [SW-1:0] r_sum;
    logic [SW-1:0] r_min;
    logic [3:0]    r_cnt;
    logic          r_valid;
    logic [PW-1:0] r_perm;

    logic [SW-1:0] w_cost_ext;
    logic          w_issue_last;
    logic          w_last_perm;

    assign w_cost_ext   = SW'(jam.Cost);
    assign w_issue_last = (r_idx == IW'(N - 1));
    assign w_last_perm  = (r_perm == LAST_PERM);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_gen_start  = 1'b0;
        unique case (r_state)
            IDLE:    w_next_state = ISSUE;
            ISSUE:   if (w_issue_last) w_next_state = DRAIN;
            DRAIN:   w_next_state = CMP;
            CMP:     w_next_state = w_last_perm ? DONE : REQ;
            REQ: begin
                w_gen_start  = 1'b1;
                w_next_state = WAIT_LO;
            end
            WAIT_LO: if (!jam.gen_done) w_next_state = WAIT_HI;
            WAIT_HI: if (jam.gen_done) w_next_state = ISSUE;
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    // W/J are loaded one step ahead so that each index is on the bus during its
    // own ISSUE cycle, and its Cost arrives during the following ISSUE/DRAIN cycle.
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_idx   <= '0;
            r_w     <= '0;
            r_j     <= '0;
            r_sum   <= '0;
            r_min   <= MIN_INIT;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_perm  <= IDENT_PERM;
        end else begin
            unique case (r_state)
                ISSUE: begin
                    if (r_idx != '0) begin
                        r_sum <= r_sum + w_cost_ext;
                    end
                    if (!w_issue_last) begin
                        r_w <= r_idx + 1'b1;
                        r_j <= perm_field(r_perm, r_idx + 1'b1);
                    end
                    r_idx <= r_idx + 1'b1;
                end
                DRAIN: begin
                    r_sum <= r_sum + w_cost_ext;
                end
                CMP: begin
                    if (r_sum < r_min) begin
                        r_min <= r_sum;
                        r_cnt <= 4'd1;
                    end else if ((r_sum == r_min) && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_sum <= '0;
                    if (w_last_perm) begin
                        r_valid <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (jam.gen_done) begin
                        r_perm <= jam.perm_in;
                        r_w    <= '0;
                        r_j    <= perm_field(jam.perm_in, '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign jam.W          = r_w;
    assign jam.J          = r_j;
    assign jam.gen_start  = w_gen_start;
    assign jam.perm_out   = r_perm;
    assign jam.MatchCount = r_cnt;
    assign jam.MinCost    = r_min;
    assign jam.Valid      = r_valid;

    // The generator reads perm_out while it works, so it must not move before capture.
    a_perm_stable: assert property (@(posedge CLK) disable iff (!RST_N)
        (r_state inside {REQ, WAIT_LO}) |=> $stable(r_perm));

    a_valid_sticky: assert property (@(posedge CLK) disable iff (!RST_N)
        r_valid |=> r_valid);

    a_sum_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        r_sum <= SW'(N * ((1 << CW) - 1)));

endmodule
